vmx_array_ctrl: RTL and testbench

Sequencing controller for a ROWS×COLS systolic array of vmx_pe_16_8 processing elements. Data and load control flow horizontally along each row; partial sums flow vertically down each column. The block accepts weight sets and input vectors on valid/ready streams, encodes weight loads into the PE `load_ctrl` protocol, skews row inputs, and deskews column results. Results are buffered in a credit-protected FIFO, because the array itself cannot stall.

---
 rtl/vmx_array_ctrl_pkg.sv | 24 ++
 rtl/vmx_array_ctrl_fifo.sv | 57 +++++
 rtl/vmx_array_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_vmx_array_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmx_array_ctrl_pkg.sv
// vmx_array_ctrl_pkg: shared definitions for the systolic-array sequencing
// controller.
//   LOAD_FLAG / LOAD_IDLE : PE load_ctrl protocol codes
//   MAX_COLS              : column limit imposed by the 7-bit load index
//   state_t               : controller FSM states
//   load_code()           : load_ctrl word carrying a weight for column col
package vmx_array_ctrl_pkg;

  localparam logic [7:0]  LOAD_FLAG = 8'h80;
  localparam logic [7:0]  LOAD_IDLE = 8'h7F;
  localparam int unsigned MAX_COLS  = 127;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_LOAD   = 1'b1
  } state_t;

  // Each PE decrements load_ctrl before passing it right, so only the PE
  // at column col sees exactly LOAD_FLAG and latches the weight.
  function automatic logic [7:0] load_code(input logic [6:0] col);
    return LOAD_FLAG | {1'b0, col};
  endfunction

endpackage

// File: rtl/vmx_array_ctrl_fifo.sv
// vmx_result_fifo: synchronous FIFO for aligned result vectors.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head entry, all zeros while empty
//   empty/full : occupancy flags
module vmx_result_fifo #(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vmx_array_ctrl.sv
// vmx_array_ctrl: sequencing controller for a ROWS x COLS systolic array.
//   clk, rst_n            : clock, synchronous active-low reset
//   w_valid/w_ready/w_data: weight beats, one column per beat
//   x_valid/x_ready/x_data/x_simd : input vectors
//   pe_simd/pe_load_ctrl/pe_data  : skewed feed into column 0 of each row
//   pe_sum                : bottom-row partial sums
//   y_valid/y_ready/y_data/y_simd : buffered result vectors
//   loaded                : a full weight set has been loaded
//   busy                  : loading, vectors in flight, or results pending
module vmx_array_ctrl
  import vmx_array_ctrl_pkg::*;
#(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned COLS           = 8,
  parameter int unsigned VECTOR_BITLEN  = 16,
  parameter int unsigned PRODUCT_BITLEN = 2 * VECTOR_BITLEN,
  parameter int unsigned FIFO_DEPTH     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [ROWS*VECTOR_BITLEN-1:0]     w_data,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [ROWS*VECTOR_BITLEN-1:0]     x_data,
  input  logic                              x_simd,
  output logic [ROWS-1:0]                   pe_simd,
  output logic [ROWS*8-1:0]                 pe_load_ctrl,
  output logic [ROWS*VECTOR_BITLEN-1:0]     pe_data,
  input  logic [COLS*PRODUCT_BITLEN-1:0]    pe_sum,
  output logic                              y_valid,
  input  logic                              y_ready,
  output logic [COLS*PRODUCT_BITLEN-1:0]    y_data,
  output logic                              y_simd,
  output logic                              loaded,
  output logic                              busy
);

  localparam int unsigned VB   = VECTOR_BITLEN;
  localparam int unsigned PB   = PRODUCT_BITLEN;
  localparam int unsigned SW   = VB + 9;          // {simd, load_ctrl, data}
  localparam int unsigned YW   = COLS * PB;
  localparam int unsigned TAGS = ROWS + COLS;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] BUBBLE = {1'b0, LOAD_IDLE, {VB{1'b0}}};

  if (COLS < 1 || COLS > MAX_COLS) begin : g_bad_cols
    $error("vmx_array_ctrl: COLS must be within 1..127");
  end
  if (FIFO_DEPTH < ROWS + COLS + 1) begin : g_bad_depth
    $error("vmx_array_ctrl: FIFO_DEPTH must be at least ROWS+COLS+1");
  end

  state_t        state;
  logic [6:0]    wcol;
  logic [CW-1:0] credits;
  logic          w_fire;
  logic          x_fire;
  logic          pop;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full;
  logic          inflight;
  logic [SW-1:0] slot [ROWS];
  logic          tag_vld  [TAGS];
  logic          tag_simd [TAGS];
  logic [YW-1:0] aligned;

  assign w_ready = rst_n;
  assign x_ready = rst_n && (state == ST_STREAM) && loaded && (credits != '0) && !w_valid;
  assign w_fire  = w_valid && w_ready;
  assign x_fire  = x_valid && x_ready;
  assign y_valid = !fifo_empty;
  assign pop     = y_valid && y_ready;
  assign busy    = (state == ST_LOAD) || inflight || !fifo_empty;

  // A beat at wcol = COLS-1 always completes the set, which also covers
  // COLS = 1 where the first beat is also the last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_STREAM;
      wcol   <= '0;
      loaded <= 1'b0;
    end else if (w_fire) begin
      if (wcol == 7'(COLS - 1)) begin
        state  <= ST_STREAM;
        wcol   <= '0;
        loaded <= 1'b1;
      end else begin
        state <= ST_LOAD;
        wcol  <= wcol + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= CW'(FIFO_DEPTH);
    end else begin
      case ({x_fire, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      slot[r] = BUBBLE;
      if (w_fire)      slot[r] = {1'b0, load_code(wcol), w_data[r*VB +: VB]};
      else if (x_fire) slot[r] = {x_simd, LOAD_IDLE, x_data[r*VB +: VB]};
    end
  end

  // Row r delays its slot by r+1 registers; data, code and mode move as one.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [SW-1:0] pipe [r+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i <= r; i++) pipe[i] <= BUBBLE;
      end else begin
        pipe[0] <= slot[r];
        for (int unsigned i = 1; i <= r; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign pe_data[r*VB +: VB]    = pipe[r][VB-1:0];
    assign pe_load_ctrl[r*8 +: 8] = pipe[r][VB+7:VB];
    assign pe_simd[r]             = pipe[r][SW-1];
  end

  // tag[k] holds the vector issued k+1 cycles ago; the last stage lines up
  // with the deskewed sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAGS; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_simd[i] <= 1'b0;
      end
    end else begin
      tag_vld[0]  <= x_fire;
      tag_simd[0] <= x_fire && x_simd;
      for (int unsigned i = 1; i < TAGS; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_simd[i] <= tag_simd[i-1];
      end
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int unsigned i = 0; i < TAGS; i++) inflight = inflight || tag_vld[i];
  end

  assign push = tag_vld[TAGS-1];

  // Column c emerges c cycles after column 0; COLS-1-c stages realign them.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int unsigned D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*PB +: PB] = pe_sum[c*PB +: PB];
    end else begin : g_dly
      logic [PB-1:0] dly [D];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < D; i++) dly[i] <= '0;
        end else begin
          dly[0] <= pe_sum[c*PB +: PB];
          for (int unsigned i = 1; i < D; i++) dly[i] <= dly[i-1];
        end
      end
      assign aligned[c*PB +: PB] = dly[D-1];
    end
  end

  vmx_result_fifo #(
    .WIDTH(YW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !fifo_full),
    .pop   (pop),
    .din   ({tag_simd[TAGS-1], aligned}),
    .dout  ({y_simd, y_data}),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_vmx_array_ctrl.sv
// tb_vmx_array_ctrl: bench for vmx_array_ctrl with a behavioural model of
// the PE array driving pe_sum and a dot-product reference for results.
module tb_vmx_array_ctrl;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned VB    = 16;
  localparam int unsigned PB    = 32;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, w_valid, w_ready, x_valid, x_ready, x_simd;
  logic                 y_valid, y_ready, y_simd, loaded, busy;
  logic [ROWS*VB-1:0]   w_data, x_data, pe_data;
  logic [ROWS-1:0]      pe_simd;
  logic [ROWS*8-1:0]    pe_load_ctrl;
  logic [COLS*PB-1:0]   pe_sum, y_data;

  vmx_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .VECTOR_BITLEN(VB),
    .PRODUCT_BITLEN(PB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_simd(x_simd),
    .pe_simd(pe_simd), .pe_load_ctrl(pe_load_ctrl), .pe_data(pe_data),
    .pe_sum(pe_sum),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_simd(y_simd),
    .loaded(loaded), .busy(busy)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Multiply-accumulate of one PE: full 16x16, or two 8x8 lanes summed.
  function automatic logic [PB-1:0] mac(input logic [VB-1:0] d, input logic [VB-1:0] w,
                                        input logic simd);
    logic [PB-1:0] a, b, e, f;
    if (simd) begin
      a = PB'(d[15:8]); b = PB'(w[15:8]);
      e = PB'(d[7:0]);  f = PB'(w[7:0]);
      return a * b + e * f;
    end
    a = PB'(d); b = PB'(w);
    return a * b;
  endfunction

  // ---------------- PE array model (external to the DUT) ----------------
  logic [VB-1:0] a_w   [ROWS][COLS] = '{default: '0};
  logic [VB-1:0] a_d   [ROWS][COLS] = '{default: '0};
  logic [7:0]    a_c   [ROWS][COLS] = '{default: 8'h7F};
  logic          a_s   [ROWS][COLS] = '{default: 1'b0};
  logic [PB-1:0] a_sum [ROWS][COLS] = '{default: '0};

  always @(posedge clk) begin : array_model
    logic [VB-1:0] in_d;
    logic [7:0]    in_c;
    logic          in_s;
    logic [PB-1:0] in_sum;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == 0) begin
          in_d = pe_data[r*VB +: VB]; in_c = pe_load_ctrl[r*8 +: 8]; in_s = pe_simd[r];
        end else begin
          in_d = a_d[r][c-1]; in_c = a_c[r][c-1]; in_s = a_s[r][c-1];
        end
        if (r == 0) in_sum = '0;
        else        in_sum = a_sum[r-1][c];
        if (in_c == 8'h80) a_w[r][c] <= in_d;
        a_d[r][c]   <= in_d;
        a_c[r][c]   <= in_c - 8'd1;
        a_s[r][c]   <= in_s;
        a_sum[r][c] <= in_sum + mac(in_d, a_w[r][c], in_s);
      end
    end
  end

  always_comb begin
    pe_sum = '0;
    for (int c = 0; c < COLS; c++) pe_sum[c*PB +: PB] = a_sum[ROWS-1][c];
  end

  // ---------------- reference: weights as matrices, results as dot products
  logic [VB-1:0]      W  [ROWS][COLS] = '{default: '0};
  logic [VB-1:0]      Wp [ROWS][COLS] = '{default: '0};
  int unsigned        ref_wcol = 0;
  logic [COLS*PB:0]   expq [$];
  logic               s_xr, s_xf;

  function automatic logic [COLS*PB-1:0] dot(input logic [ROWS*VB-1:0] x, input logic simd);
    logic [COLS*PB-1:0] y;
    logic [PB-1:0]      acc;
    y = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = '0;
      for (int r = 0; r < ROWS; r++) acc = acc + mac(x[r*VB +: VB], W[r][c], simd);
      y[c*PB +: PB] = acc;
    end
    return y;
  endfunction

  // One clock: sample handshakes before the edge, update the reference,
  // check any popped result, then return at the following negedge.
  task automatic tick();
    logic wf, pf;
    logic [COLS*PB:0] e;
    #2;
    s_xr = x_ready;
    wf   = rst_n && w_valid && w_ready;
    s_xf = rst_n && x_valid && x_ready;
    pf   = rst_n && y_valid && y_ready;
    if (wf) begin
      for (int r = 0; r < ROWS; r++) Wp[r][ref_wcol] = w_data[r*VB +: VB];
      if (ref_wcol == COLS - 1) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) W[r][c] = Wp[r][c];
        ref_wcol = 0;
      end else begin
        ref_wcol++;
      end
    end
    if (s_xf) expq.push_back({x_simd, dot(x_data, x_simd)});
    if (pf) begin
      if (expq.size() == 0) begin
        check("y_spurious", y_valid, 1'b0);
      end else begin
        e = expq.pop_front();
        check("y_result", {y_simd, y_data}, e);
      end
    end
    if (!rst_n) begin
      expq.delete();
      ref_wcol = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [VB-1:0] wgen(input int unsigned kind, input int r, input int c);
    case (kind)
      0:       return (r == c) ? VB'(1) : VB'(0);
      2:       return VB'(16 * r + c);
      default: return VB'($urandom);
    endcase
  endfunction

  task automatic load_set(input int unsigned kind);
    x_valid = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      w_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) w_data[r*VB +: VB] = wgen(kind, r, c);
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic rand_x();
    for (int r = 0; r < ROWS; r++) x_data[r*VB +: VB] = VB'($urandom);
    x_simd = 1'($urandom);
  endtask

  task automatic drain();
    x_valid = 1'b0;
    w_valid = 1'b0;
    y_ready = 1'b1;
    for (int i = 0; i < 300 && (expq.size() != 0 || busy); i++) tick();
    check("drain_left", expq.size(), 0);
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned n, acc;
    logic [COLS*PB-1:0] ev;

    rst_n = 1'b0; w_valid = 1'b0; x_valid = 1'b0; x_simd = 1'b0;
    w_data = '0; x_data = '0; y_ready = 1'b0;

    // Reset values while rst_n is held low for three cycles.
    repeat (3) tick();
    check("rst_y_valid", y_valid, 1'b0);
    check("rst_x_ready", x_ready, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_ctrl", pe_load_ctrl, {ROWS{8'h7F}});
    check("rst_pe_data", pe_data, '0);
    check("rst_pe_simd", pe_simd, '0);
    check("rst_y_data", y_data, '0);
    check("rst_y_simd", y_simd, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_w_ready", w_ready, 1'b1);
    check("rel_x_ready", x_ready, 1'b0);
    check("rel_loaded", loaded, 1'b0);

    // Load encoding: beat k lands on row 0 one cycle later, row 3 four later.
    for (int k = 0; k < 12; k++) begin
      w_valid = (k < COLS);
      for (int r = 0; r < ROWS; r++) w_data[r*VB +: VB] = VB'(16 * r + k);
      tick();
      check("enc_row0_ctrl", pe_load_ctrl[7:0], (k < 8) ? 8'(8'h80 + k) : 8'h7F);
      check("enc_row3_ctrl", pe_load_ctrl[31:24],
            (k >= 3 && k < 11) ? 8'(8'h80 + k - 3) : 8'h7F);
      if (k < 8) check("enc_row0_data", pe_data[15:0], VB'(k));
    end
    w_valid = 1'b0;
    check("enc_loaded", loaded, 1'b1);

    // Identity compute and first-result latency.
    load_set(0);
    y_ready = 1'b1;
    x_simd  = 1'b0;
    for (int r = 0; r < ROWS; r++) x_data[r*VB +: VB] = VB'(r + 1);
    x_valid = 1'b1;
    s_xf = 1'b0;
    for (int i = 0; i < 20 && !s_xf; i++) tick();
    x_valid = 1'b0;
    check("id_accept", s_xf, 1'b1);
    n = 1;
    while (!y_valid && n < 40) begin
      tick();
      n++;
    end
    check("id_latency", n, 17);
    ev = '0;
    for (int c = 0; c < COLS; c++) ev[c*PB +: PB] = PB'(c + 1);
    check("id_y_data", y_data, ev);
    check("id_y_simd", y_simd, 1'b0);
    drain();

    // Weight preemption: old weights before the set, new weights after.
    load_set(1);
    y_ready = 1'b1;
    rand_x(); x_valid = 1'b1;
    tick();
    check("pre_accept", s_xf, 1'b1);
    rand_x();
    for (int b = 0; b < COLS; b++) begin
      w_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) w_data[r*VB +: VB] = VB'($urandom);
      tick();
      check("preempt_x_ready", s_xr, 1'b0);
    end
    w_valid = 1'b0;
    tick();
    check("post_x_ready", s_xr, 1'b1);
    check("post_accept", s_xf, 1'b1);
    x_valid = 1'b0;
    drain();

    // Randomised traffic with gapped weight loads and random backpressure.
    for (int i = 0; i < 400; i++) begin
      w_valid = ($urandom_range(0, 9) == 0) || (ref_wcol != 0 && $urandom_range(0, 1) == 0);
      for (int r = 0; r < ROWS; r++) w_data[r*VB +: VB] = VB'($urandom);
      x_valid = 1'($urandom);
      rand_x();
      y_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    x_valid = 1'b0;
    for (int i = 0; i < 20 && ref_wcol != 0; i++) begin
      w_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) w_data[r*VB +: VB] = VB'($urandom);
      tick();
    end
    w_valid = 1'b0;
    check("rand_loaded", loaded, 1'b1);
    drain();

    // Backpressure: credits admit exactly DEPTH vectors.
    y_ready = 1'b0;
    x_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      rand_x();
      tick();
      if (s_xf) acc++;
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_x_ready", s_xr, 1'b0);
    check("bp_y_valid", y_valid, 1'b1);
    acc = 0;
    y_ready = 1'b1;
    tick();
    if (s_xf) acc++;
    y_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_x();
      tick();
      if (s_xf) acc++;
    end
    check("bp_one_pop", acc, 1);
    drain();

    // Mid-stream reset with five vectors in flight.
    y_ready = 1'b1;
    x_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      rand_x();
      tick();
      if (s_xf) acc++;
    end
    x_valid = 1'b0;
    check("mr_sent", acc, 5);
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("mr_loaded", loaded, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (y_valid) n++;
    end
    check("mr_stale_y", n, 0);
    load_set(1);
    y_ready = 1'b0;
    x_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      rand_x();
      tick();
      if (s_xf) acc++;
    end
    check("mr_credits", acc, DEPTH);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
